// File: rtl/cpu_pkg.sv
// Core-wide datapath constants shared by the IF/ID buffer and the ID/EX registers.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_buffer.sv
// IF/ID buffer of DEPTH {pc, inst} pairs; a pushed word shows on out_* after one edge, with no bypass.
// Stalls fetch (in_ready=0) only when full and gives no pop-bypass; flush drops everything, including this cycle's input.
module if_fetch_buffer #(
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // A handshake during flush is still acknowledged on in_ready; it simply never lands.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  assign out_pc   = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign out_inst = out_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign count    = count_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer at DEPTH=4: reset, fill/drain, streaming, full+pop, flush, wrap and reset.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_out_inst got %h exp 0", out_inst); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_inst = 32'h1000 + 32'(i);
      tick();
      n_cmp++; if (count !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, i + 1); end
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid i=%0d got %b exp 1", i, out_valid); end
      n_cmp++; if (out_pc !== 32'(i * 4)) begin n_bad++; $display("FAIL drain_pc i=%0d got %h exp %h", i, out_pc, i * 4); end
      n_cmp++; if (out_inst !== 32'h1000 + 32'(i)) begin n_bad++; $display("FAIL drain_inst i=%0d got %h exp %h", i, out_inst, 32'h1000 + i); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL drain_count got %0d exp 0", count); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL drain_nop got %h exp 0", out_inst); end
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc = 32'h100 + 32'(4 * k); in_inst = 32'h2000 + 32'(k);
      tick();
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL stream_count k=%0d got %0d exp 1", k, count); end
      n_cmp++; if (out_pc !== 32'h100 + 32'(4 * k)) begin n_bad++; $display("FAIL stream_pc k=%0d got %h exp %h", k, out_pc, 32'h100 + 4 * k); end
      n_cmp++; if (out_inst !== 32'h2000 + 32'(k)) begin n_bad++; $display("FAIL stream_inst k=%0d got %h exp %h", k, out_inst, 32'h2000 + k); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL stream_drain got %0d exp 0", count); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h204; exp_pc[1] = 32'h208; exp_pc[2] = 32'h20C; exp_pc[3] = 32'h300;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_inst = 32'h3000 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fullpop_pre_count got %0d exp 4", count); end
    in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h3300; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fullpop_in_ready got %b exp 0", in_ready); end
    tick();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fullpop_count got %0d exp 3", count); end
    n_cmp++; if (out_pc !== 32'h204) begin n_bad++; $display("FAIL fullpop_head got %h exp 204", out_pc); end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fullpop_accept got %0d exp 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_pc !== exp_pc[i]) begin n_bad++; $display("FAIL fullpop_drain i=%0d got %h exp %h", i, out_pc, exp_pc[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fullpop_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_inst = 32'h4000 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h4040; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL flush_nop got %h exp 0", out_inst); end
    in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h5000;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL flush_after_count got %0d exp 1", count); end
    n_cmp++; if (out_pc !== 32'h500) begin n_bad++; $display("FAIL flush_after_pc got %h exp 500", out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_pc = 32'h600 + 32'(4 * i); in_inst = 32'h6000 + 32'(i); out_ready = 1'b0;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (out_pc !== 32'h600 + 32'(4 * i)) begin n_bad++; $display("FAIL wrap_pc i=%0d got %h exp %h", i, out_pc, 32'h600 + 4 * i); end
      n_cmp++; if (out_inst !== 32'h6000 + 32'(i)) begin n_bad++; $display("FAIL wrap_inst i=%0d got %h exp %h", i, out_inst, 32'h6000 + i); end
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * i); in_inst = 32'h7000 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rst_pre_count got %0d exp 2", count); end
    rst_n = 1'b0; flush = 1'b1; in_pc = 32'h780;
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    in_valid = 1'b1; in_pc = 32'h800; in_inst = 32'h8000;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 32'h800) begin n_bad++; $display("FAIL rst_after_pc got %h exp 800", out_pc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_full_pop();
    test_flush();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
